// File: rtl/color_freq_scanner.sv
// Four-channel TCS3200 frequency scanner: steps the filter through R/G/B/C, settles,
// counts synchronised pulse edges per gate window and publishes all four counts together.
module color_freq_scanner #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GATE_DIV   = 16,
    parameter int unsigned SETTLE_CYC = 10_000,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Pulse,
    input  logic             Start,
    output logic [1:0]       FilterSel,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Red,
    output logic [CNT_W-1:0] Green,
    output logic [CNT_W-1:0] Blue,
    output logic [CNT_W-1:0] Clear,
    output logic [3:0]       Overflow
);

    localparam int unsigned GATE_CYC = CLK_HZ / GATE_DIV;
    localparam int unsigned GATE_W   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam int unsigned SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        GATE    = 3'd2,
        STORE   = 3'd3,
        PUBLISH = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              ch_q, ch_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic [GATE_W-1:0]       gate_q, gate_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [3:0][CNT_W-1:0]   shadow_q, shadow_d;
    logic [3:0]              shovf_q, shovf_d;
    logic [3:0][CNT_W-1:0]   pub_q, pub_d;
    logic [3:0]              pubovf_q, pubovf_d;
    logic [1:0]              filt_q, filt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [1:0]              sync_q, sync_d;
    logic                    last_q, last_d;
    logic                    rise_c;

    // {S2,S3} code for channel order red, green, blue, clear
    function automatic logic [1:0] filter_code(input logic [1:0] ch);
        case (ch)
            2'd0:    filter_code = 2'b00;
            2'd1:    filter_code = 2'b11;
            2'd2:    filter_code = 2'b01;
            default: filter_code = 2'b10;
        endcase
    endfunction

    assign rise_c = sync_q[1] & ~last_q;

    always_comb begin
        sync_d   = {sync_q[0], Pulse};
        last_d   = sync_q[1];
        state_d  = state_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        gate_d   = gate_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        shovf_d  = shovf_q;
        pub_d    = pub_q;
        pubovf_d = pubovf_q;
        filt_d   = filt_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = SETTLE;
                    ch_d     = 2'd0;
                    settle_d = SET_W'(SETTLE_CYC - 1);
                    filt_d   = filter_code(2'd0);
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = GATE;
                    gate_d  = GATE_W'(GATE_CYC - 1);
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            GATE: begin
                // saturate instead of wrapping; a lost edge at max is flagged
                if (rise_c) begin
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_W'(1);
                end
                if (gate_q == '0) state_d = STORE;
                else              gate_d  = gate_q - GATE_W'(1);
            end
            STORE: begin
                shadow_d[ch_q] = cnt_q;
                shovf_d[ch_q]  = ovf_q;
                if (ch_q != 2'd3) begin
                    ch_d     = ch_q + 2'd1;
                    state_d  = SETTLE;
                    settle_d = SET_W'(SETTLE_CYC - 1);
                    filt_d   = filter_code(ch_q + 2'd1);
                end else begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                pub_d    = shadow_q;
                pubovf_d = shovf_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            settle_q <= '0;
            gate_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            shadow_q <= '0;
            shovf_q  <= '0;
            pub_q    <= '0;
            pubovf_q <= '0;
            filt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sync_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            settle_q <= settle_d;
            gate_q   <= gate_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            shadow_q <= shadow_d;
            shovf_q  <= shovf_d;
            pub_q    <= pub_d;
            pubovf_q <= pubovf_d;
            filt_q   <= filt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sync_q   <= sync_d;
            last_q   <= last_d;
        end
    end

    assign FilterSel = filt_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Red       = pub_q[0];
    assign Green     = pub_q[1];
    assign Blue      = pub_q[2];
    assign Clear     = pub_q[3];
    assign Overflow  = pubovf_q;

endmodule

// File: doc/color_freq_scanner.md
Name: color_freq_scanner

Overview:
Parametrised four-channel frequency scanner for the TCS3200 colour sensor. It drives the sensor's filter-select lines (S2,S3) through red, green, blue and clear in turn. For each filter it waits a settle time, then counts sensor output rising edges over a fixed gate window. All four counts are published together with a one-cycle Done strobe, so the colour-decision logic sees a coherent RGBC sample instead of one frequency per request.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
GATE_DIV, 16, gate window = CLK_HZ/GATE_DIV cycles (GATE_CYC); must divide CLK_HZ exactly
SETTLE_CYC, 10_000, cycles held on each new filter before counting starts; must be >= 3
CNT_W, 10, width of each published count

Ports:
CLK  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Pulse  input  1  TCS3200 OUT, asynchronous to CLK
Start  input  1  level request; sampled only in IDLE
FilterSel  output  2  {S2,S3} to sensor: red=00, green=11, blue=01, clear=10
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle strobe when Red/Green/Blue/Clear are updated
Red  output  CNT_W  red-filter edge count
Green  output  CNT_W  green-filter edge count
Blue  output  CNT_W  blue-filter edge count
Clear  output  CNT_W  clear-filter edge count
Overflow  output  4  per-channel saturation flags {clear,blue,green,red}, bit0=red

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, FilterSel=00, Busy=0, Done=0, Red/Green/Blue/Clear=0, Overflow=0. Synchroniser, edge detector, counters and shadow registers also clear. Reset mid-scan aborts the scan with no publish.
- Input path: 2-FF synchroniser on Pulse, then a previous-value register. A rising edge is sync=1 and last=0. The pipeline runs every cycle, including IDLE.
- States: IDLE, SETTLE, GATE, STORE, PUBLISH. A 2-bit channel index ch selects channels in the order red(0), green(1), blue(2), clear(3).
- IDLE: if Start=1 at a clock edge, next state is SETTLE with ch=0.
- SETTLE: FilterSel = code(ch). Stay exactly SETTLE_CYC cycles, then go to GATE. Edges are not counted.
- GATE: stay exactly GATE_CYC cycles. Each detected edge increments the channel counter. Increment is saturating at 2^CNT_W-1; an increment attempted at max sets that channel's overflow bit. The counter clears on GATE entry.
- STORE: one cycle. Write the counter and overflow bit into the shadow slot for ch. If ch<3, increment ch and go to SETTLE; else go to PUBLISH.
- PUBLISH: one cycle. Copy all four shadows and all four shadow overflow bits to the outputs in the same edge. Done=1 for this cycle only. Next state is IDLE.
- Outputs hold their last published value until the next PUBLISH; they never change mid-scan.
- Start held high re-triggers on the cycle after returning to IDLE (free-running scan). Start changes while Busy are ignored.
- Latency: Start sampled at edge k gives Done high in the cycle beginning at edge k + 4*(SETTLE_CYC+GATE_CYC+1) + 1.
- FilterSel holds its last code through STORE, PUBLISH and IDLE. It changes only on SETTLE entry.
- Counter width internally is CNT_W bits plus saturation logic; no wrap-around is ever visible.
- GATE_CYC and the SETTLE counter use $clog2-sized registers.

Test Plan:
Bench parameters are CLK_HZ=1000, GATE_DIV=10 (GATE_CYC=100), SETTLE_CYC=8, CNT_W=5. The stimulus is a pulse generator whose period is chosen from FilterSel.
1. Reset: assert Reset_n=0 mid-GATE of the green channel -> all outputs 0 immediately (asynchronously), Busy=0. After release with Start=0, the block stays IDLE with Done never asserted.
2. Basic scan: periods red=4, green=5, blue=10, clear=20 cycles; Start pulsed 1 cycle -> Done exactly 437 cycles after the Start sample. Red=25, Green=20, Blue=10, Clear=5, Overflow=0000, Busy low on the following cycle.
3. FilterSel sequence: during test 2, FilterSel reads 00, 11, 01, 10, with each change on SETTLE entry and 109 cycles apart.
4. Saturation: clear period=2 (50 edges) -> Clear=31, Overflow=1000. Other channels unchanged from test 2.
5. Coherence/re-trigger: Start held high, periods changed to red=2 mid-scan (during blue) -> the first Done still shows the old Red=25. The next scan starts the cycle after IDLE, and the second Done, 438 cycles after the first, shows Red=31 with Overflow[0]=1. Outputs never change between Done strobes.
6. No input: Pulse tied low -> Done after 437 cycles with all counts 0 and Overflow=0. A Start pulse while Busy=1 does not shorten or extend the scan.
